// File: rtl/coherence_bus_ctrl_if.sv
// rtl/coherence_bus_ctrl_if.sv - core-side and RAM-side signal bundle of the snooping bus controller
// Per-core fields are packed with core i at slice i.
interface coherence_bus_ctrl_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] dload;
    logic [CPUS-1:0]        cctrans;
    logic [CPUS-1:0]        ccwrite;
    logic [CPUS-1:0]        ccwait;
    logic [CPUS-1:0]        ccinv;
    logic [CPUS*ADDR_W-1:0] ccsnoopaddr;
    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - round-robin snooping bus controller for CPUS cores onto one RAM port
// Optional macro COHERENCE_C2C_EN: dirty snoop hit forwards the word to the initiator during the writeback.
module coherence_bus_ctrl #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    coherence_bus_ctrl_if.master bus
);
    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [2:0] {IDLE, SNOOP, REPLY, WB, IFETCH} state_t;

    state_t state_q, state_d;
    idx_t   init_q, init_d;
    idx_t   rr_q, rr_d;
    logic   d_found, i_found, resp_found;
    idx_t   d_idx, i_idx, resp_idx;
    logic   access;
    logic [ADDR_W-1:0] init_daddr;

`ifndef COHERENCE_C2C_EN
    logic wb_done_q, wb_done_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            init_q  <= '0;
            rr_q    <= idx_t'(CPUS - 1);
`ifndef COHERENCE_C2C_EN
            wb_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            rr_q    <= rr_d;
`ifndef COHERENCE_C2C_EN
            wb_done_q <= wb_done_d;
`endif
        end
    end

    // Scan in descending distance from rr_q so the nearest requester after the pointer wins.
    always_comb begin
        int c;
        c       = 0;
        d_found = 1'b0;
        d_idx   = '0;
        i_found = 1'b0;
        i_idx   = '0;
        for (int k = CPUS; k >= 1; k--) begin
            c = (int'(rr_q) + k) % CPUS;
            if (bus.dREN[c] || bus.dWEN[c]) begin
                d_found = 1'b1;
                d_idx   = idx_t'(c);
            end
            if (bus.iREN[c]) begin
                i_found = 1'b1;
                i_idx   = idx_t'(c);
            end
        end
    end

    always_comb begin
        resp_found = 1'b0;
        resp_idx   = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != int'(init_q) && bus.cctrans[j] && bus.dWEN[j]) begin
                resp_found = 1'b1;
                resp_idx   = idx_t'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        rr_d    = rr_q;
`ifndef COHERENCE_C2C_EN
        wb_done_d = wb_done_q;
`endif
        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.iload       = '0;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        access     = (bus.ramstate == RAM_ACCESS);
        init_daddr = bus.daddr[int'(init_q)*ADDR_W +: ADDR_W];

        if (state_q == SNOOP || state_q == REPLY) begin
            for (int j = 0; j < CPUS; j++) begin
                if (j != int'(init_q)) begin
                    bus.ccwait[j] = 1'b1;
                    bus.ccinv[j]  = bus.ccwrite[init_q];
                    bus.ccsnoopaddr[j*ADDR_W +: ADDR_W] = init_daddr;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (d_found) begin
                    init_d  = d_idx;
                    rr_d    = d_idx;
                    state_d = (bus.dWEN[d_idx] && !bus.cctrans[d_idx]) ? WB : SNOOP;
                end else if (i_found) begin
                    init_d  = i_idx;
                    rr_d    = i_idx;
                    state_d = IFETCH;
                end
            end
            SNOOP: state_d = REPLY;
            REPLY: begin
`ifdef COHERENCE_C2C_EN
                if (resp_found) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[int'(resp_idx)*ADDR_W +: ADDR_W];
                    bus.ramstore = bus.dstore[int'(resp_idx)*WORD_W +: WORD_W];
                    bus.dload[int'(init_q)*WORD_W +: WORD_W] = bus.dstore[int'(resp_idx)*WORD_W +: WORD_W];
                    if (access) bus.dwait[resp_idx] = 1'b0;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = init_daddr;
                    bus.dload[int'(init_q)*WORD_W +: WORD_W] = bus.ramload;
                end
                if (access) begin
                    bus.dwait[init_q] = 1'b0;
                    state_d = bus.cctrans[init_q] ? SNOOP : IDLE;
                end
`else
                // Responder writeback first, then the initiator rereads the fresh word from RAM.
                if (resp_found && !wb_done_q) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[int'(resp_idx)*ADDR_W +: ADDR_W];
                    bus.ramstore = bus.dstore[int'(resp_idx)*WORD_W +: WORD_W];
                    if (access) begin
                        bus.dwait[resp_idx] = 1'b0;
                        wb_done_d = 1'b1;
                    end
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = init_daddr;
                    bus.dload[int'(init_q)*WORD_W +: WORD_W] = bus.ramload;
                    if (access) begin
                        bus.dwait[init_q] = 1'b0;
                        wb_done_d = 1'b0;
                        state_d = bus.cctrans[init_q] ? SNOOP : IDLE;
                    end
                end
`endif
            end
            WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = init_daddr;
                bus.ramstore = bus.dstore[int'(init_q)*WORD_W +: WORD_W];
                if (access) begin
                    bus.dwait[init_q] = 1'b0;
                    state_d = IDLE;
                end
            end
            IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[int'(init_q)*ADDR_W +: ADDR_W];
                bus.iload[int'(init_q)*WORD_W +: WORD_W] = bus.ramload;
                if (access) begin
                    bus.iwait[init_q] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - directed table-driven bench for coherence_bus_ctrl with four cores
module tb_coherence_bus_ctrl;
    localparam int CPUS = 4;
    localparam int AW = 32;
    localparam int WW = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
    localparam logic [31:0] K = 32'h5A5A_5A5A;

    typedef struct {
        logic        rst;
        logic [3:0]  iren, dren, dwen, cct;
        logic [1:0]  rs;
        logic [3:0]  e_iwait, e_dwait, e_ccwait;
        logic        e_ren, e_wen;
        logic [31:0] e_addr;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   passed = 0;
    int   total = 0;
    vec_t tbl[$];

    coherence_bus_ctrl_if #(.CPUS(CPUS), .ADDR_W(AW), .WORD_W(WW)) bus ();
    coherence_bus_ctrl #(.CPUS(CPUS), .ADDR_W(AW), .WORD_W(WW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;
    assign bus.ramload = bus.ramaddr ^ K;

    function automatic vec_t mk(logic r, logic [3:0] i, d, w, c, logic [1:0] s,
                                logic [3:0] eiw, edw, ecw, logic er, ew, logic [31:0] ea);
        vec_t v;
        v.rst = r; v.iren = i; v.dren = d; v.dwen = w; v.cct = c; v.rs = s;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_ccwait = ecw;
        v.e_ren = er; v.e_wen = ew; v.e_addr = ea;
        return v;
    endfunction

    function automatic vec_t idl(logic r, logic [3:0] i, d, w, c, logic [1:0] s);
        return mk(r, i, d, w, c, s, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic r, input logic [3:0] i, d, w, c, cw, input logic [1:0] s);
        @(posedge CLK); #1;
        RST = r; bus.iREN = i; bus.dREN = d; bus.dWEN = w; bus.cctrans = c; bus.ccwrite = cw;
        bus.ramstate = s;
        @(negedge CLK);
    endtask

    task automatic apply(input vec_t v, input int n);
        drive(v.rst, v.iren, v.dren, v.dwen, v.cct, 4'h0, v.rs);
        chk($sformatf("v%0d iwait", n), {28'h0, bus.iwait}, {28'h0, v.e_iwait});
        chk($sformatf("v%0d dwait", n), {28'h0, bus.dwait}, {28'h0, v.e_dwait});
        chk($sformatf("v%0d ccwait", n), {28'h0, bus.ccwait}, {28'h0, v.e_ccwait});
        chk($sformatf("v%0d ccinv", n), {28'h0, bus.ccinv}, 32'h0);
        chk($sformatf("v%0d ramREN", n), {31'h0, bus.ramREN}, {31'h0, v.e_ren});
        chk($sformatf("v%0d ramWEN", n), {31'h0, bus.ramWEN}, {31'h0, v.e_wen});
        chk($sformatf("v%0d ramaddr", n), bus.ramaddr, v.e_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.cctrans = '0; bus.ccwrite = '0;
        bus.ramstate = ACC;
        bus.iaddr  = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
        bus.daddr  = {32'h100, 32'hC0, 32'h40, 32'h80};
        bus.dstore = {32'h1111_0003, 32'h1111_0002, 32'hDEAD_BEEF, 32'h1111_0000};

        // Reset values, then instruction fetches for cores 0 and 1
        tbl.push_back(idl(1, 4'h0, 4'h0, 4'h0, 4'h0, ACC));
        tbl.push_back(idl(0, 4'b0011, 4'h0, 4'h0, 4'h0, ACC));
        tbl.push_back(mk(0, 4'b0011, 0, 0, 0, ACC, 4'b1110, 4'hF, 0, 1, 0, 32'h1000));
        tbl.push_back(idl(0, 4'b0010, 4'h0, 4'h0, 4'h0, ACC));
        tbl.push_back(mk(0, 4'b0010, 0, 0, 0, ACC, 4'b1101, 4'hF, 0, 1, 0, 32'h1004));
        tbl.push_back(idl(0, 4'h0, 4'h0, 4'h0, 4'h0, ACC));
        // RAM BUSY for five cycles, then ACCESS
        tbl.push_back(idl(0, 4'b0001, 4'h0, 4'h0, 4'h0, FREE));
        for (int b = 0; b < 5; b++) tbl.push_back(mk(0, 4'b0001, 0, 0, 0, BUSY, 4'hF, 4'hF, 0, 1, 0, 32'h1000));
        tbl.push_back(mk(0, 4'b0001, 0, 0, 0, ACC, 4'b1110, 4'hF, 0, 1, 0, 32'h1000));
        tbl.push_back(idl(0, 4'h0, 4'h0, 4'h0, 4'h0, ACC));
        // Writeback stuck on ERROR, aborted by reset
        tbl.push_back(idl(0, 4'h0, 4'h0, 4'b0001, 4'h0, ERR));
        for (int b = 0; b < 3; b++) tbl.push_back(mk(0, 0, 0, 4'b0001, 0, ERR, 4'hF, 4'hF, 0, 0, 1, 32'h80));
        tbl.push_back(mk(1, 0, 0, 4'b0001, 0, ERR, 4'hF, 4'hF, 0, 0, 1, 32'h80));
        tbl.push_back(idl(0, 4'h0, 4'h0, 4'h0, 4'h0, ACC));
        // All four cores coherent-read, core 0 re-requests; pending ifetch waits for data to clear
        tbl.push_back(idl(0, 4'b0010, 4'hF, 4'h0, 4'hF, ACC));
        tbl.push_back(mk(0, 4'b0010, 4'hF, 0, 4'hF, ACC, 4'hF, 4'hF, 4'b1110, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 4'b1110, 0, 4'b1110, ACC, 4'hF, 4'b1110, 4'b1110, 1, 0, 32'h80));
        tbl.push_back(idl(0, 4'b0010, 4'hF, 4'h0, 4'hF, ACC));
        tbl.push_back(mk(0, 4'b0010, 4'hF, 0, 4'hF, ACC, 4'hF, 4'hF, 4'b1101, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 4'b1101, 0, 4'b1101, ACC, 4'hF, 4'b1101, 4'b1101, 1, 0, 32'h40));
        tbl.push_back(idl(0, 4'b0010, 4'b1101, 4'h0, 4'b1101, ACC));
        tbl.push_back(mk(0, 4'b0010, 4'b1101, 0, 4'b1101, ACC, 4'hF, 4'hF, 4'b1011, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 4'b1001, 0, 4'b1001, ACC, 4'hF, 4'b1011, 4'b1011, 1, 0, 32'hC0));
        tbl.push_back(idl(0, 4'b0010, 4'b1001, 4'h0, 4'b1001, ACC));
        tbl.push_back(mk(0, 4'b0010, 4'b1001, 0, 4'b1001, ACC, 4'hF, 4'hF, 4'b0111, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 4'b0001, 0, 4'b0001, ACC, 4'hF, 4'b0111, 4'b0111, 1, 0, 32'h100));
        tbl.push_back(idl(0, 4'b0010, 4'b0001, 4'h0, 4'b0001, ACC));
        tbl.push_back(mk(0, 4'b0010, 4'b0001, 0, 4'b0001, ACC, 4'hF, 4'hF, 4'b1110, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 4'h0, 0, 4'h0, ACC, 4'hF, 4'b1110, 4'b1110, 1, 0, 32'h80));
        tbl.push_back(idl(0, 4'b0010, 4'h0, 4'h0, 4'h0, ACC));
        tbl.push_back(mk(0, 4'b0010, 0, 0, 0, ACC, 4'b1101, 4'hF, 0, 1, 0, 32'h1004));
        tbl.push_back(idl(0, 4'h0, 4'h0, 4'h0, 4'h0, ACC));

        repeat (2) @(posedge CLK);
        foreach (tbl[n]) apply(tbl[n], n);

        // Core 1 BusRdX to 0x40: snoop broadcast, then RAM read
        drive(0, 0, 4'b0010, 0, 4'b0010, 4'b0010, ACC);
        drive(0, 0, 4'b0010, 0, 4'b0010, 4'b0010, ACC);
        chk("rdx snoopaddr0", bus.ccsnoopaddr[0 +: 32], 32'h40);
        chk("rdx snoopaddr1", bus.ccsnoopaddr[32 +: 32], 32'h0);
        chk("rdx ccinv", {28'h0, bus.ccinv}, 32'hD);
        chk("rdx ccwait", {28'h0, bus.ccwait}, 32'hD);
        drive(0, 0, 4'b0010, 0, 4'b0000, 4'b0010, ACC);
        chk("rdx dload1", bus.dload[32 +: 32], 32'h40 ^ K);
        chk("rdx dwait", {28'h0, bus.dwait}, 32'hD);
        chk("rdx ramREN", {31'h0, bus.ramREN}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, ACC);
        chk("rdx release", {28'h0, bus.ccwait}, 32'h0);

        // Instruction fetch data for core 2
        drive(0, 4'b0100, 0, 0, 0, 0, ACC);
        drive(0, 4'b0100, 0, 0, 0, 0, ACC);
        chk("if iload2", bus.iload[64 +: 32], 32'h1008 ^ K);
        chk("if iwait", {28'h0, bus.iwait}, 32'hB);
        drive(0, 0, 0, 0, 0, 0, ACC);

        // Core 0 reads 0x80, core 1 answers the snoop with a dirty word
        drive(0, 0, 4'b0001, 0, 4'b0001, 0, ACC);
        drive(0, 0, 4'b0001, 4'b0010, 4'b0011, 0, ACC);
        chk("c2c ccwait", {28'h0, bus.ccwait}, 32'hE);
        drive(0, 0, 4'b0001, 4'b0010, 4'b0010, 0, ACC);
        chk("c2c ramWEN", {31'h0, bus.ramWEN}, 32'h1);
        chk("c2c ramstore", bus.ramstore, 32'hDEAD_BEEF);
        chk("c2c ramaddr", bus.ramaddr, 32'h40);
`ifdef COHERENCE_C2C_EN
        chk("c2c dload0", bus.dload[0 +: 32], 32'hDEAD_BEEF);
        chk("c2c dwait", {28'h0, bus.dwait}, 32'hC);
`else
        chk("c2c dwait", {28'h0, bus.dwait}, 32'hD);
        drive(0, 0, 4'b0001, 0, 0, 0, ACC);
        chk("reread ramREN", {31'h0, bus.ramREN}, 32'h1);
        chk("reread ramaddr", bus.ramaddr, 32'h80);
        chk("reread dload0", bus.dload[0 +: 32], 32'h80 ^ K);
        chk("reread dwait", {28'h0, bus.dwait}, 32'hE);
`endif
        drive(0, 0, 0, 0, 0, 0, ACC);
        chk("c2c idle", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);

        // Two-word block from core 1 while core 0 also requests
        drive(0, 0, 4'b0011, 0, 4'b0011, 0, ACC);
        drive(0, 0, 4'b0011, 0, 4'b0011, 0, ACC);
        chk("blk snoop1", {28'h0, bus.ccwait}, 32'hD);
        drive(0, 0, 4'b0011, 0, 4'b0011, 0, ACC);
        chk("blk word1", {28'h0, bus.dwait}, 32'hD);
        chk("blk dload1", bus.dload[32 +: 32], 32'h40 ^ K);
        drive(0, 0, 4'b0011, 0, 4'b0011, 0, ACC);
        chk("blk resnoop", {28'h0, bus.ccwait}, 32'hD);
        chk("blk resnoop ren", {31'h0, bus.ramREN}, 32'h0);
        drive(0, 0, 4'b0011, 0, 4'b0001, 0, ACC);
        chk("blk word2", {28'h0, bus.dwait}, 32'hD);
        drive(0, 0, 4'b0001, 0, 4'b0001, 0, ACC);
        chk("blk idle", {28'h0, bus.ccwait}, 32'h0);
        drive(0, 0, 4'b0001, 0, 4'b0001, 0, ACC);
        chk("blk next init", {28'h0, bus.ccwait}, 32'hE);
        drive(0, 0, 0, 0, 0, 0, ACC);
        chk("blk next done", {28'h0, bus.dwait}, 32'hE);
        drive(0, 0, 0, 0, 0, 0, ACC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
